rf_riscv_sb: RTL and testbench
==============================

Name: rf_riscv_sb

Overview:
Parametrised successor of the core's integer register file, for the pipelined core. It provides NUM_RD asynchronous read ports and one synchronous write port, with register 0 hardwired to zero. An optional write-to-read bypass is selectable by parameter. An integrated scoreboard tracks registers that have a pending write, so the decode stage can stall on hazards. The block sits between decode (reads, issue) and writeback (write, clear).

Parameters:
XLEN, 32, data width of each register
DEPTH, 32, number of registers; power of two, at least 2
NUM_RD, 2, number of read ports, 1..4
BYPASS, 1, 1 = write data forwarded combinationally to same-cycle reads of the same address; 0 = no forwarding
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous active-high reset
write_enable_i  input  1  writeback strobe
write_addr_i  input  AW  writeback register index
write_data_i  input  XLEN  writeback data
read_addr_i  input  NUM_RD*AW  packed read indices; port k occupies bits [k*AW +: AW]
read_data_o  output  NUM_RD*XLEN  packed read data; port k occupies bits [k*XLEN +: XLEN]
busy_o  output  NUM_RD  port k addresses a register with a pending write
issue_i  input  1  decode issued an instruction that will write issue_addr_i
issue_addr_i  input  AW  destination of the issued instruction
flush_i  input  1  pipeline flush; discards all pending-write marks
busy_cnt_o  output  AW+1  number of registers currently marked busy

Behaviour:
- Reset (rst_i=1, asynchronous, takes effect immediately):
  - all DEPTH registers clear to 0;
  - all busy bits clear to 0;
  - read_data_o reads 0 on every port; busy_o=0; busy_cnt_o=0.
  - Reset has priority over every other input.
  - When reset is asserted mid-operation, it discards any in-flight write or issue at the same edge.
- Register 0:
  - always reads 0;
  - writes to it are ignored;
  - issue to it never sets a busy bit;
  - busy_o for a port addressing register 0 is always 0.
- Write: on a rising edge with write_enable_i=1 and write_addr_i!=0, the register takes write_data_i. Without bypass, the new value is visible on reads in the next cycle (read latency 0, write latency 1).
- Read: fully combinational, mem[addr]. When BYPASS=1, write_enable_i=1, write_addr_i==read address and the address is not 0, the port returns write_data_i in the same cycle. Each port decodes independently; all ports may address the same register.
- Scoreboard: one busy bit per register, updated on the rising edge in priority order:
  1. flush_i=1: all bits clear, including any issue or write this cycle. The register write itself still occurs.
  2. issue_i=1 and issue_addr_i!=0: busy[issue_addr_i] sets. This holds even if a write to the same address clears it in the same cycle; the new producer wins.
  3. write_enable_i=1: busy[write_addr_i] clears, unless item 2 set it this cycle.
- A write to a non-busy register is legal; its busy bit stays 0.
- busy_o[k]:
  - nominally busy[read_addr k], combinational;
  - when BYPASS=1 and a same-cycle write matches that address, busy_o[k]=0 (data is forwarded);
  - when BYPASS=0, busy_o[k] reflects the registered bit only.
- busy_cnt_o: combinational popcount of the busy vector, range 0..DEPTH-1 (register 0 never counts).
- Issue to an already-busy register leaves it busy; there is no per-register count (WAW is handled upstream).
- No X propagation: every output is defined from reset onward.

Test Plan:
- Reset then read all: assert rst_i mid-stream after writing 0xDEADBEEF to register 5 → read_data_o=0 on all ports immediately; busy_cnt_o=0.
- Basic write/read, NUM_RD=2, BYPASS=0:
  - write 0x12345678 to register 3 at edge N; read ports both at 3 → 0 during cycle N, 0x12345678 from cycle N+1;
  - write 0xFFFFFFFF to register 0 → register 0 still reads 0.
- Bypass, BYPASS=1: write_enable_i=1, addr 7, data 0xA5A5A5A5, with port 1 reading register 7 in the same cycle → read_data port 1=0xA5A5A5A5 and busy_o[1]=0 that cycle; port 0 reading register 8 is unaffected.
- Scoreboard set/clear:
  - issue register 4 at edge N → busy_o=1 for a port on register 4 from N+1, busy_cnt_o=1;
  - write register 4 at edge N+3 → busy 0 from N+4, count 0;
  - issue register 0 → count stays 0.
- Simultaneous events:
  - issue register 9 and write register 9 at the same edge → busy stays 1 and the data updates;
  - issue registers 2, 3, 6 on successive edges, then flush_i alongside a write to register 6 → all busy 0, count 0, register 6 holds the written data.

Source files
------------

// File: rtl/rf_riscv_sb.sv
// Integer register file with NUM_RD combinational read ports, one synchronous
// write port, optional write-to-read bypass and a pending-write scoreboard.
module rf_riscv_sb #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   write_enable_i,
  input  logic [AW-1:0]          write_addr_i,
  input  logic [XLEN-1:0]        write_data_i,
  input  logic [NUM_RD*AW-1:0]   read_addr_i,
  output logic [NUM_RD*XLEN-1:0] read_data_o,
  output logic [NUM_RD-1:0]      busy_o,
  input  logic                   issue_i,
  input  logic [AW-1:0]          issue_addr_i,
  input  logic                   flush_i,
  output logic [AW:0]            busy_cnt_o
);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wr_valid;

  assign wr_valid = write_enable_i && (write_addr_i != {AW{1'b0}});

  // Register array; entry 0 is never written so it stays zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {XLEN{1'b0}};
      end
    end else if (wr_valid) begin
      mem[write_addr_i] <= write_data_i;
    end
  end

  // Scoreboard next state: flush beats issue, issue beats the writeback clear.
  always_comb begin
    busy_nxt = busy;
    if (write_enable_i) begin
      busy_nxt[write_addr_i] = 1'b0;
    end
    if (issue_i && (issue_addr_i != {AW{1'b0}})) begin
      busy_nxt[issue_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_nxt = {DEPTH{1'b0}};
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy <= {DEPTH{1'b0}};
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read ports; a forwarded write also hides the pending mark on that port.
  // Forwarding is suppressed during reset so every port reads zero.
  always_comb begin
    read_data_o = {(NUM_RD*XLEN){1'b0}};
    busy_o      = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0] ra;
      logic          hit;
      ra  = read_addr_i[k*AW +: AW];
      hit = (BYPASS != 0) && !rst_i && wr_valid && (write_addr_i == ra);
      if (hit) begin
        read_data_o[k*XLEN +: XLEN] = write_data_i;
        busy_o[k]                   = 1'b0;
      end else begin
        read_data_o[k*XLEN +: XLEN] = mem[ra];
        busy_o[k]                   = busy[ra];
      end
    end
  end

  // Population count of the busy vector.
  always_comb begin
    busy_cnt_o = {(AW+1){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_o = busy_cnt_o + {{AW{1'b0}}, busy[i]};
    end
  end

endmodule

// File: tb/tb_rf_riscv_sb.sv
// Directed bench for rf_riscv_sb: one instance with bypass, one without,
// driven by the same stimulus.
module tb_rf_riscv_sb;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [AW-1:0]   wa;
  logic [XLEN-1:0] wd;
  logic [AW-1:0]   ra0, ra1;
  logic            issue;
  logic [AW-1:0]   ia;
  logic            flush;

  logic [2*AW-1:0]   read_addr;
  logic [2*XLEN-1:0] rd_b, rd_n;
  logic [1:0]        busy_b, busy_n;
  logic [AW:0]       cnt_b, cnt_n;

  int tests = 0;
  int fails = 0;

  assign read_addr = {ra1, ra0};

  always #5 clk = ~clk;

  rf_riscv_sb #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1)) dut (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .write_addr_i(wa),
    .write_data_i(wd), .read_addr_i(read_addr), .read_data_o(rd_b),
    .busy_o(busy_b), .issue_i(issue), .issue_addr_i(ia), .flush_i(flush),
    .busy_cnt_o(cnt_b)
  );

  rf_riscv_sb #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .BYPASS(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .write_enable_i(we), .write_addr_i(wa),
    .write_data_i(wd), .read_addr_i(read_addr), .read_data_o(rd_n),
    .busy_o(busy_n), .issue_i(issue), .issue_addr_i(ia), .flush_i(flush),
    .busy_cnt_o(cnt_n)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; issue = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = 5'd0; wd = 32'd0; ra0 = 5'd0; ra1 = 5'd0;
    issue = 1'b0; ia = 5'd0; flush = 1'b0;
    #2;
    check_eq("reset_rd", {32'd0, rd_b}, 64'd0);
    check_eq("reset_cnt", {58'd0, cnt_b}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Write 0xDEADBEEF to r5 while issuing r5, then reset mid-cycle
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; issue = 1'b1; ia = 5'd5;
    ra0 = 5'd5; ra1 = 5'd5;
    #1;
    check_eq("nb_same_cycle", {32'd0, rd_n[31:0]}, 64'd0);
    check_eq("byp_same_cycle", {32'd0, rd_b[31:0]}, 64'h00000000DEADBEEF);
    tick();
    idle();
    #1;
    check_eq("r5_written", {32'd0, rd_n[31:0]}, 64'h00000000DEADBEEF);
    check_eq("r5_busy_after_issue_write", {62'd0, busy_n}, 64'd3);
    check_eq("cnt_one", {58'd0, cnt_n}, 64'd1);
    rst = 1'b1;
    #1;
    check_eq("async_rst_rd_b", {rd_b}, 64'd0);
    check_eq("async_rst_rd_n", {rd_n}, 64'd0);
    check_eq("async_rst_cnt", {58'd0, cnt_b}, 64'd0);
    check_eq("async_rst_busy", {62'd0, busy_b}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Basic write latency without bypass
    we = 1'b1; wa = 5'd3; wd = 32'h12345678; ra0 = 5'd3; ra1 = 5'd3;
    #1;
    check_eq("nb_r3_cycle_n", rd_n, 64'd0);
    check_eq("byp_r3_cycle_n", rd_b, 64'h1234567812345678);
    tick();
    idle();
    #1;
    check_eq("nb_r3_cycle_n1", rd_n, 64'h1234567812345678);

    // Writes to r0 are ignored and never bypassed
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra0 = 5'd0; ra1 = 5'd0;
    #1;
    check_eq("r0_no_bypass", rd_b, 64'd0);
    tick();
    idle();
    #1;
    check_eq("r0_still_zero", rd_n, 64'd0);

    // Bypass on port 1 (r7 busy), port 0 on r8 unaffected
    issue = 1'b1; ia = 5'd7;
    tick();
    idle();
    ra0 = 5'd8; ra1 = 5'd7;
    #1;
    check_eq("r7_busy", {62'd0, busy_b}, 64'd2);
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
    #1;
    check_eq("byp_rd", rd_b, 64'hA5A5A5A500000000);
    check_eq("byp_busy", {62'd0, busy_b}, 64'd0);
    check_eq("nb_rd", rd_n, 64'd0);
    check_eq("nb_busy", {62'd0, busy_n}, 64'd2);
    tick();
    idle();
    #1;
    check_eq("r7_cleared_cnt", {58'd0, cnt_n}, 64'd0);

    // Scoreboard set at N, clear by write at N+3
    ra0 = 5'd4; ra1 = 5'd0;
    issue = 1'b1; ia = 5'd4;
    tick();
    idle();
    #1;
    check_eq("r4_busy", {62'd0, busy_n}, 64'd1);
    check_eq("r4_cnt", {58'd0, cnt_b}, 64'd1);
    tick(); tick();
    check_eq("r4_still_busy", {62'd0, busy_b}, 64'd1);
    we = 1'b1; wa = 5'd4; wd = 32'h00000044;
    tick();
    idle();
    #1;
    check_eq("r4_clear", {62'd0, busy_n}, 64'd0);
    check_eq("r4_clear_cnt", {58'd0, cnt_n}, 64'd0);
    check_eq("r4_data", {32'd0, rd_n[31:0]}, 64'h0000000000000044);

    // Issue to r0 never marks
    issue = 1'b1; ia = 5'd0;
    tick();
    idle();
    #1;
    check_eq("r0_issue_cnt", {58'd0, cnt_b}, 64'd0);
    check_eq("r0_issue_busy", {62'd0, busy_b}, 64'd0);

    // Issue and write r9 at the same edge: new producer wins
    issue = 1'b1; ia = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h00000099;
    ra0 = 5'd9;
    tick();
    idle();
    #1;
    check_eq("r9_busy", {62'd0, busy_n}, 64'd1);
    check_eq("r9_data", {32'd0, rd_n[31:0]}, 64'h0000000000000099);
    check_eq("r9_cnt", {58'd0, cnt_n}, 64'd1);
    we = 1'b1; wa = 5'd9; wd = 32'h00000099;
    tick();
    idle();

    // Issue r2, r3, r6 then flush with a write to r6
    issue = 1'b1; ia = 5'd2; tick();
    ia = 5'd3; tick();
    ia = 5'd6; tick();
    idle();
    #1;
    check_eq("three_busy_cnt", {58'd0, cnt_b}, 64'd3);
    ra0 = 5'd6; ra1 = 5'd2;
    flush = 1'b1; we = 1'b1; wa = 5'd6; wd = 32'h66666666;
    tick();
    idle();
    #1;
    check_eq("flush_cnt", {58'd0, cnt_n}, 64'd0);
    check_eq("flush_busy", {60'd0, busy_n, busy_b}, 64'd0);
    check_eq("flush_r6_data", {32'd0, rd_n[31:0]}, 64'h0000000066666666);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
